// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared types and helpers for the program counter with return
//            stack: the priority-encoded per-cycle action and the
//            stack-pointer width function.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

  // At most one action takes effect per cycle. Reset is handled separately
  // in the register processes because it overrides everything.
  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_LOAD = 3'd1,
    ACT_CALL = 3'd2,
    ACT_RET  = 3'd3,
    ACT_INC  = 3'd4
  } action_e;

  // The stack pointer has to count 0..DEPTH inclusive, so it needs
  // $clog2(DEPTH+1) bits rather than $clog2(DEPTH).
  function automatic int sp_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // Priority: load > call > ret > en.
  function automatic action_e decode_action(input logic load, input logic call,
                                            input logic ret, input logic en);
    action_e act;
    act = ACT_NONE;
    if (load)      act = ACT_LOAD;
    else if (call) act = ACT_CALL;
    else if (ret)  act = ACT_RET;
    else if (en)   act = ACT_INC;
    return act;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_counter_stack_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_counter_stack_if
// Purpose  : Controller-to-program-counter bundle.
// Ports    : master - drives en/load/call/ret/data, observes counter status
//            slave  - the counter: takes strobes, drives cnt, wrap, sp,
//                     stk_full, stk_empty, stk_err
// Revision : 1.0 - initial release
// ============================================================================
interface pc_counter_stack_if #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
);

  localparam int SPW = pc_pkg::sp_width(DEPTH);

  logic             en;
  logic             load;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] cnt;
  logic             wrap;
  logic [SPW-1:0]   sp;
  logic             stk_full;
  logic             stk_empty;
  logic             stk_err;

  modport master (
    output en, load, call, ret, data,
    input  cnt, wrap, sp, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  en, load, call, ret, data,
    output cnt, wrap, sp, stk_full, stk_empty, stk_err
  );

endinterface
`default_nettype wire

// File: rtl/pc_counter_stack_ret_stack.sv
`default_nettype none
// ============================================================================
// Module   : ret_stack
// Purpose  : LIFO of return addresses. Entry sp-1 is the top; entries at
//            index >= sp are stale and never read.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            push_i/push_data_i - push request and value
//            pop_i             - pop request
//            top_o             - value at sp-1 (valid when not empty)
//            sp_o              - number of valid entries
//            full_o/empty_o    - sp == DEPTH / sp == 0
//            ovf_o/udf_o       - push while full / pop while empty (this cycle)
// Revision : 1.0 - initial release
// ============================================================================
module ret_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             push_data_i,
  output logic [WIDTH-1:0]             top_o,
  output logic [sp_width(DEPTH)-1:0]   sp_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         ovf_o,
  output logic                         udf_o
);

  localparam int SPW = sp_width(DEPTH);
  // Index width for the storage array; sp itself is one bit wider when
  // DEPTH is a power of two.
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q;
  logic [SPW-1:0]   sp_d;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    top_idx;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;
  assign ovf_o   = push_i && full_o;
  assign udf_o   = pop_i && empty_o;

  assign wr_idx  = IW'(sp_q);
  assign top_idx = IW'(sp_q - SPW'(1));
  assign top_o   = mem_q[top_idx];
  assign sp_o    = sp_q;

  always_comb begin
    sp_d = sp_q;
    if (do_push)     sp_d = sp_q + SPW'(1);
    else if (do_pop) sp_d = sp_q - SPW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  // Contents need no reset: only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_idx] <= push_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/pc_counter_stack.sv
`default_nettype none
// ============================================================================
// Module   : pc_counter_stack
// Purpose  : Fetch-stage program counter with configurable width/step,
//            optional saturation, one-cycle wrap flag and a hardware
//            return-address stack for call/ret.
// Ports    : clk - clock; rst - synchronous active-high reset
//            bus - slave side of pc_counter_stack_if (strobes, data in;
//                  cnt, wrap, sp, stk_full, stk_empty, stk_err out)
// Revision : 1.0 - initial release
// ============================================================================
module pc_counter_stack
  import pc_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int DEPTH     = 4,
  parameter int STEP      = 1,
  parameter int RESET_VAL = 0,
  parameter int SATURATE  = 0
) (
  input  logic               clk,
  input  logic               rst,
  pc_counter_stack_if.slave  bus
);

  localparam int               SPW      = sp_width(DEPTH);
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);

  action_e          act;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic [WIDTH-1:0] top;
  logic [SPW-1:0]   sp;
  logic             full, empty, ovf, udf;

  assign act   = decode_action(bus.load, bus.call, bus.ret, bus.en);
  // Extra bit captures the overflow; the low bits double as the
  // (never saturated) return address pushed on call.
  assign sum   = {1'b0, cnt_q} + STEP_EXT;
  assign carry = sum[WIDTH];

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk         (clk),
    .rst         (rst),
    .push_i      (act == ACT_CALL),
    .pop_i       (act == ACT_RET),
    .push_data_i (sum[WIDTH-1:0]),
    .top_o       (top),
    .sp_o        (sp),
    .full_o      (full),
    .empty_o     (empty),
    .ovf_o       (ovf),
    .udf_o       (udf)
  );

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    err_d  = err_q | ovf | udf;
    case (act)
      ACT_LOAD: cnt_d = bus.data;
      ACT_CALL: if (!full)  cnt_d = bus.data;
      ACT_RET:  if (!empty) cnt_d = top;
      ACT_INC: begin
        wrap_d = carry;
        if (carry && (SATURATE != 0)) cnt_d = '1;
        else                          cnt_d = sum[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= WIDTH'(RESET_VAL);
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.cnt       = cnt_q;
  assign bus.wrap      = wrap_q;
  assign bus.sp        = sp;
  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
  assign bus.stk_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_counter_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_counter_stack
// Purpose  : Directed self-checking bench. Instance A uses default
//            parameters, instance B uses SATURATE=1, STEP=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_counter_stack;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  pc_counter_stack_if #(.WIDTH(5), .DEPTH(4)) ifa ();
  pc_counter_stack_if #(.WIDTH(5), .DEPTH(4)) ifb ();

  pc_counter_stack #(.WIDTH(5), .DEPTH(4), .STEP(1), .RESET_VAL(0), .SATURATE(0))
    dut_a (.clk(clk), .rst(rst_a), .bus(ifa));

  pc_counter_stack #(.WIDTH(5), .DEPTH(4), .STEP(3), .RESET_VAL(0), .SATURATE(1))
    dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  typedef struct {
    string      tag;
    bit         inst;
    logic [4:0] cnt;
    logic [2:0] sp;
    logic       wrap;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input string fld, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus on the selected instance (the other idles),
  // queue the expected post-edge state, then pop and compare after the edge.
  task automatic step(input string tag, input bit inst,
                      input logic r, input logic l, input logic c,
                      input logic rt, input logic e, input logic [4:0] d,
                      input logic [4:0] ecnt, input logic [2:0] esp,
                      input logic ewrap, input logic eerr);
    exp_t x;
    @(negedge clk);
    rst_a = 1'b0; ifa.load = 1'b0; ifa.call = 1'b0; ifa.ret = 1'b0; ifa.en = 1'b0; ifa.data = '0;
    rst_b = 1'b0; ifb.load = 1'b0; ifb.call = 1'b0; ifb.ret = 1'b0; ifb.en = 1'b0; ifb.data = '0;
    if (!inst) begin
      rst_a = r; ifa.load = l; ifa.call = c; ifa.ret = rt; ifa.en = e; ifa.data = d;
    end else begin
      rst_b = r; ifb.load = l; ifb.call = c; ifb.ret = rt; ifb.en = e; ifb.data = d;
    end
    x.tag = tag; x.inst = inst; x.cnt = ecnt; x.sp = esp; x.wrap = ewrap; x.err = eerr;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    if (!x.inst) begin
      chk(x.tag, "cnt",   int'(ifa.cnt),       int'(x.cnt));
      chk(x.tag, "sp",    int'(ifa.sp),        int'(x.sp));
      chk(x.tag, "wrap",  int'(ifa.wrap),      int'(x.wrap));
      chk(x.tag, "err",   int'(ifa.stk_err),   int'(x.err));
      chk(x.tag, "full",  int'(ifa.stk_full),  int'(x.sp == 3'd4));
      chk(x.tag, "empty", int'(ifa.stk_empty), int'(x.sp == 3'd0));
    end else begin
      chk(x.tag, "cnt",   int'(ifb.cnt),       int'(x.cnt));
      chk(x.tag, "sp",    int'(ifb.sp),        int'(x.sp));
      chk(x.tag, "wrap",  int'(ifb.wrap),      int'(x.wrap));
      chk(x.tag, "err",   int'(ifb.stk_err),   int'(x.err));
      chk(x.tag, "full",  int'(ifb.stk_full),  int'(x.sp == 3'd4));
      chk(x.tag, "empty", int'(ifb.stk_empty), int'(x.sp == 3'd0));
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.load = 1'b0; ifa.call = 1'b0; ifa.ret = 1'b0; ifa.en = 1'b0; ifa.data = '0;
    ifb.load = 1'b0; ifb.call = 1'b0; ifb.ret = 1'b0; ifb.en = 1'b0; ifb.data = '0;

    //        tag          inst rst ld cl rt en data   cnt    sp  wrap err
    step("rst_a",      0, 1, 0, 0, 0, 0, 5'h00, 5'h00, 3'd0, 0, 0);
    step("rst_b",      1, 1, 0, 0, 0, 0, 5'h00, 5'h00, 3'd0, 0, 0);

    // Load and increment across the modulo boundary.
    step("load1D",     0, 0, 1, 0, 0, 0, 5'h1D, 5'h1D, 3'd0, 0, 0);
    step("inc1E",      0, 0, 0, 0, 0, 1, 5'h00, 5'h1E, 3'd0, 0, 0);
    step("inc1F",      0, 0, 0, 0, 0, 1, 5'h00, 5'h1F, 3'd0, 0, 0);
    step("inc00",      0, 0, 0, 0, 0, 1, 5'h00, 5'h00, 3'd0, 1, 0);
    step("inc01",      0, 0, 0, 0, 0, 1, 5'h00, 5'h01, 3'd0, 0, 0);
    step("inc02",      0, 0, 0, 0, 0, 1, 5'h00, 5'h02, 3'd0, 0, 0);

    // Wrap then idle: idle must clear wrap.
    step("load1F",     0, 0, 1, 0, 0, 0, 5'h1F, 5'h1F, 3'd0, 0, 0);
    step("incwrap",    0, 0, 0, 0, 0, 1, 5'h00, 5'h00, 3'd0, 1, 0);
    step("idle",       0, 0, 0, 0, 0, 0, 5'h00, 5'h00, 3'd0, 0, 0);

    // Simple call / inc / ret.
    step("load05",     0, 0, 1, 0, 0, 0, 5'h05, 5'h05, 3'd0, 0, 0);
    step("call10",     0, 0, 0, 1, 0, 0, 5'h10, 5'h10, 3'd1, 0, 0);
    step("inc11",      0, 0, 0, 0, 0, 1, 5'h00, 5'h11, 3'd1, 0, 0);
    step("ret06",      0, 0, 0, 0, 1, 0, 5'h00, 5'h06, 3'd0, 0, 0);

    // Fill the stack, overflow, drain, underflow.
    step("load00",     0, 0, 1, 0, 0, 0, 5'h00, 5'h00, 3'd0, 0, 0);
    step("call08",     0, 0, 0, 1, 0, 0, 5'h08, 5'h08, 3'd1, 0, 0);
    step("call09",     0, 0, 0, 1, 0, 0, 5'h09, 5'h09, 3'd2, 0, 0);
    step("call0A",     0, 0, 0, 1, 0, 0, 5'h0A, 5'h0A, 3'd3, 0, 0);
    step("call0B",     0, 0, 0, 1, 0, 0, 5'h0B, 5'h0B, 3'd4, 0, 0);
    step("callovf",    0, 0, 0, 1, 0, 0, 5'h0C, 5'h0B, 3'd4, 0, 1);
    step("ret0B",      0, 0, 0, 0, 1, 0, 5'h00, 5'h0B, 3'd3, 0, 1);
    step("ret0A",      0, 0, 0, 0, 1, 0, 5'h00, 5'h0A, 3'd2, 0, 1);
    step("ret09",      0, 0, 0, 0, 1, 0, 5'h00, 5'h09, 3'd1, 0, 1);
    step("ret01",      0, 0, 0, 0, 1, 0, 5'h00, 5'h01, 3'd0, 0, 1);
    step("retudf",     0, 0, 0, 0, 1, 0, 5'h00, 5'h01, 3'd0, 0, 1);
    step("idle_err",   0, 0, 0, 0, 0, 0, 5'h00, 5'h01, 3'd0, 0, 1);

    // Priority: load over everything, call over ret/en, ret over en.
    step("call15",     0, 0, 0, 1, 0, 0, 5'h15, 5'h15, 3'd1, 0, 1);
    step("all07",      0, 0, 1, 1, 1, 1, 5'h07, 5'h07, 3'd1, 0, 1);
    step("callret03",  0, 0, 0, 1, 1, 1, 5'h03, 5'h03, 3'd2, 0, 1);
    step("reten08",    0, 0, 0, 0, 1, 1, 5'h00, 5'h08, 3'd1, 0, 1);
    step("reten02",    0, 0, 0, 0, 1, 1, 5'h00, 5'h02, 3'd0, 0, 1);

    // Reset wins over a simultaneous call and clears the sticky error.
    step("rstcall",    0, 1, 0, 1, 0, 0, 5'h1A, 5'h00, 3'd0, 0, 0);

    // Saturating instance, STEP=3.
    step("b_load1C",   1, 0, 1, 0, 0, 0, 5'h1C, 5'h1C, 3'd0, 0, 0);
    step("b_inc1F",    1, 0, 0, 0, 0, 1, 5'h00, 5'h1F, 3'd0, 0, 0);
    step("b_sat1",     1, 0, 0, 0, 0, 1, 5'h00, 5'h1F, 3'd0, 1, 0);
    step("b_sat2",     1, 0, 0, 0, 0, 1, 5'h00, 5'h1F, 3'd0, 1, 0);
    step("b_load1F",   1, 0, 1, 0, 0, 0, 5'h1F, 5'h1F, 3'd0, 0, 0);
    // Return address wraps (1F+3 -> 02) even when saturating.
    step("b_call04",   1, 0, 0, 1, 0, 0, 5'h04, 5'h04, 3'd1, 0, 0);
    step("b_ret02",    1, 0, 0, 0, 1, 0, 5'h00, 5'h02, 3'd0, 0, 0);
    step("b_inc05",    1, 0, 0, 0, 0, 1, 5'h00, 5'h05, 3'd0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
